psum_accum_ctrl: RTL and testbench
==================================

# psum_accum_ctrl

Multi-channel partial-sum accumulation controller for the 3x3 row-stationary PE array. It sequences the per-channel output stream leaving the last PE row. It owns a local psum buffer with one entry per output pixel. For channel 0 it stores raw psums; for each later channel it performs read-add-write with saturation. On the last channel it emits the finished output pixels. It replaces hand-driven psum FIFO enables and mux selects with one counter/FSM-driven block in the clk1 domain.

## Interface
Parameters:
- DATA_WIDTH, 16, psum/output width, signed two's complement
- OFM_SIZE, 62, output feature map side; pixels per channel PIX = OFM_SIZE*OFM_SIZE
- NUM_CHANNEL, 3, input channels accumulated per output map (>=1)
- ADDR_WIDTH, 12, buffer address width; must satisfy 2^ADDR_WIDTH >= PIX
- CH_WIDTH, 5, channel counter width; must satisfy 2^CH_WIDTH > NUM_CHANNEL

Ports:
- clk1  input  1  sole clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- start_conv  input  1  one-cycle pulse; begins a new accumulation run
- psum_valid  input  1  psum_in carries one pixel psum this cycle
- psum_in  input  DATA_WIDTH  psum from the last PE row, raster order
- data_output  output  DATA_WIDTH  finished (all-channel) output pixel
- data_output_valid  output  1  data_output valid this cycle
- cnt_channel  output  CH_WIDTH  channel currently being accumulated
- last_channel  output  1  high while cnt_channel == NUM_CHANNEL-1 and busy
- busy  output  1  high in ACCUM
- done  output  1  one-cycle pulse after the final pixel is emitted
- sat_flag  output  1  sticky; set on any saturating add in the current run

## Operation
- FSM states: IDLE, ACCUM, DONE.
  - IDLE -> ACCUM on start_conv. This clears the pixel address and cnt_channel, and clears sat_flag.
  - ACCUM -> DONE when psum_valid is accepted with addr==PIX-1 and cnt_channel==NUM_CHANNEL-1.
  - DONE -> IDLE unconditionally after one cycle.
- Buffer: PIX x DATA_WIDTH register array, combinational read, synchronous write. Contents are not reset; channel 0 overwrites every entry before any read.
- Per accepted psum_valid in ACCUM, at entry addr:
  - cnt_channel==0: sum = psum_in.
  - Otherwise: sum = sat(buf[addr] + psum_in).
  - buf[addr] <= sum.
  - If last_channel: data_output <= sum and data_output_valid <= 1.
- Addressing:
  - addr increments per accepted psum.
  - At addr==PIX-1, addr wraps to 0 and cnt_channel increments.
  - On the final channel, the wrap coincides with the DONE transition.
- Arithmetic: the add is performed at DATA_WIDTH+1 bits.
  - Result > 2^(DW-1)-1 clamps to 0x7FFF (for DW=16); result < -2^(DW-1) clamps to 0x8000.
  - Either clamp sets sat_flag.
  - NUM_CHANNEL==1 never adds, so it never saturates.
- Ignored inputs:
  - psum_valid in IDLE or DONE is ignored: no write, no output.
  - start_conv while in ACCUM or DONE is ignored; the run continues.
- No backpressure: the downstream consumer must accept every data_output_valid beat.

## Timing
- Reset (rst_n low, async): state IDLE, addr=0, cnt_channel=0. All outputs are 0: data_output, data_output_valid, last_channel, busy, done, sat_flag.
- Reset mid-run aborts immediately. The buffer content is then stale and harmless, since the next run's channel 0 rewrites it.
- start_conv sampled at edge N: busy=1 from N+1. A psum_valid at edge N+1 is the first accepted.
- Latency: psum_valid at edge K produces data_output_valid and data_output at K+1 (one registered stage). The buffer write also lands at K.
- No read-after-write hazard: consecutive psums target different addresses, and the same address recurs only after PIX cycles (PIX>=1). For PIX==1, the write at K is visible to the combinational read at K+1.
- Final pixel accepted at edge F: at F+1, data_output_valid=1, state DONE, busy=0, done=1. At F+2, done=0 and the state is IDLE, so a new start_conv is accepted from edge F+2.
- psum_valid may have gaps of any length; counters hold while it is low.
- Maximum throughput is one psum per clk1 cycle.

## Test plan
Bench parameters: OFM_SIZE=2 (PIX=4), NUM_CHANNEL=3, DATA_WIDTH=16.

- **Basic accumulate.** After start_conv, send channel psums {1,2,3,4}, {10,20,30,40}, {100,200,300,400} back-to-back.
  - Exactly 4 valid outputs {111,222,333,444}, each one cycle after its final-channel input.
  - done pulses one cycle after the last input; cnt_channel steps 0,1,2; last_channel is high only during the third channel.
- **Saturation.** Send 0x7000 on every channel at pixel 0 and -0x7000 on every channel at pixel 1.
  - Pixel 0 outputs 0x7FFF, pixel 1 outputs 0x8000, sat_flag=1.
  - The next start_conv clears sat_flag.
- **Gaps and ignored inputs.**
  - Random 0-5 cycle gaps between psum_valid produce the same outputs as the basic test.
  - psum_valid pulses in IDLE produce no output and do not advance the address.
  - A start_conv during ACCUM changes nothing.
- **Reset mid-run.** Assert rst_n low during channel 1, pixel 2.
  - All outputs go to 0 asynchronously.
  - A new run with psums {5,5,5,5} x 3 outputs {15,15,15,15}, proving channel 0 overwrites stale data.
- **Back-to-back runs.** Issue start_conv on the cycle after done.
  - The second run is accepted and its outputs are independent of the first run.
- **NUM_CHANNEL=1 variant.** Send psums {-3,0,7,9}.
  - Outputs are {-3,0,7,9}; sat_flag stays 0 and last_channel stays high throughout the run.

Source files
------------

// File: rtl/psum_accum_ctrl_if.sv
// Psum stream interface for psum_accum_ctrl.
//   psum_valid / psum_in           : psum stream from the last PE row (raster order)
//   data_output / data_output_valid: finished output pixel stream, no backpressure
// master = producer/consumer side (PE array + downstream), slave = accumulator.
interface psum_accum_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  psum_valid;
  logic [DATA_WIDTH-1:0] psum_in;
  logic [DATA_WIDTH-1:0] data_output;
  logic                  data_output_valid;

  modport master (
    output psum_valid,
    output psum_in,
    input  data_output,
    input  data_output_valid
  );

  modport slave (
    input  psum_valid,
    input  psum_in,
    output data_output,
    output data_output_valid
  );
endinterface

// File: rtl/psum_accum_ctrl.sv
// Multi-channel partial-sum accumulation controller.
// Channel 0 psums are stored raw into a per-pixel buffer; later channels do a
// saturating read-add-write. Sums produced on the last channel are emitted.
// Ports:
//   clk1              : sole clock, rising edge
//   rst_n             : asynchronous active-low reset
//   start_conv        : one-cycle pulse starting a run (honoured in IDLE only)
//   psum_if (slave)   : psum_valid/psum_in in, data_output/data_output_valid out
//   cnt_channel       : channel being accumulated
//   last_channel      : busy and on the final channel
//   busy              : FSM in ACCUM
//   done              : one cycle after the final pixel is emitted
//   sat_flag          : sticky saturation indicator for the current run
module psum_accum_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int OFM_SIZE    = 62,
  parameter int NUM_CHANNEL = 3,
  parameter int ADDR_WIDTH  = 12,
  parameter int CH_WIDTH    = 5
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic                start_conv,
  psum_accum_ctrl_if.slave    psum_if,
  output logic [CH_WIDTH-1:0] cnt_channel,
  output logic                last_channel,
  output logic                busy,
  output logic                done,
  output logic                sat_flag
);

  localparam int PIX   = OFM_SIZE * OFM_SIZE;
  localparam int IDX_W = (PIX > 1) ? $clog2(PIX) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIX - 1);
  localparam logic [CH_WIDTH-1:0]   LAST_CH   = CH_WIDTH'(NUM_CHANNEL - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [CH_WIDTH-1:0]    cnt_channel_q, cnt_channel_d;
  logic [DATA_WIDTH-1:0]  data_output_q, data_output_d;
  logic                   data_output_valid_q, data_output_valid_d;
  logic                   sat_flag_q, sat_flag_d;

  // Buffer: not reset, channel 0 rewrites every entry before any read.
  logic [DATA_WIDTH-1:0]  buf_q [PIX];
  logic                   wr_en;
  logic [DATA_WIDTH-1:0]  rd_data;

  logic signed [DATA_WIDTH:0] wide_sum;
  logic                   overflow;
  logic                   first_ch;
  logic [DATA_WIDTH-1:0]  sum;
  logic                   sat_hit;

  assign rd_data = buf_q[addr_q[IDX_W-1:0]];

  // Add at DATA_WIDTH+1 bits; overflow shows as disagreement of the top two bits.
  always_comb begin
    wide_sum = $signed({rd_data[DATA_WIDTH-1], rd_data})
             + $signed({psum_if.psum_in[DATA_WIDTH-1], psum_if.psum_in});
    overflow = wide_sum[DATA_WIDTH] ^ wide_sum[DATA_WIDTH-1];
    first_ch = (cnt_channel_q == '0);
    sat_hit  = 1'b0;
    if (first_ch) begin
      sum = psum_if.psum_in;
    end else if (overflow) begin
      sum     = wide_sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
      sat_hit = 1'b1;
    end else begin
      sum = wide_sum[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d             = state_q;
    addr_d              = addr_q;
    cnt_channel_d       = cnt_channel_q;
    data_output_d       = data_output_q;
    data_output_valid_d = 1'b0;
    sat_flag_d          = sat_flag_q;
    wr_en               = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_conv) begin
          state_d       = ACCUM;
          addr_d        = '0;
          cnt_channel_d = '0;
          sat_flag_d    = 1'b0;
        end
      end
      ACCUM: begin
        if (psum_if.psum_valid) begin
          wr_en = 1'b1;
          if (sat_hit) begin
            sat_flag_d = 1'b1;
          end
          if (cnt_channel_q == LAST_CH) begin
            data_output_d       = sum;
            data_output_valid_d = 1'b1;
          end
          if (addr_q == LAST_ADDR) begin
            addr_d = '0;
            // Channel count holds on the final channel; the run ends instead.
            if (cnt_channel_q == LAST_CH) begin
              state_d = DONE;
            end else begin
              cnt_channel_d = cnt_channel_q + 1'b1;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q             <= IDLE;
      addr_q              <= '0;
      cnt_channel_q       <= '0;
      data_output_q       <= '0;
      data_output_valid_q <= 1'b0;
      sat_flag_q          <= 1'b0;
    end else begin
      state_q             <= state_d;
      addr_q              <= addr_d;
      cnt_channel_q       <= cnt_channel_d;
      data_output_q       <= data_output_d;
      data_output_valid_q <= data_output_valid_d;
      sat_flag_q          <= sat_flag_d;
    end
  end

  always_ff @(posedge clk1) begin
    if (wr_en) begin
      buf_q[addr_q[IDX_W-1:0]] <= sum;
    end
  end

  assign busy                      = (state_q == ACCUM);
  assign done                      = (state_q == DONE);
  assign last_channel              = busy && (cnt_channel_q == LAST_CH);
  assign cnt_channel               = cnt_channel_q;
  assign sat_flag                  = sat_flag_q;
  assign psum_if.data_output       = data_output_q;
  assign psum_if.data_output_valid = data_output_valid_q;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
module tb_psum_accum_ctrl;
  localparam int DW  = 16;
  localparam int OFM = 2;
  localparam int PIX = OFM * OFM;
  localparam int NC  = 3;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  logic       rst_n;
  logic       start_conv;
  logic [1:0] cnt_channel;
  logic       last_channel, busy, done, sat_flag;

  logic       start1;
  logic [0:0] cnt1;
  logic       last1, busy1, done1, sat1;

  psum_accum_ctrl_if #(.DATA_WIDTH(DW)) sif ();
  psum_accum_ctrl_if #(.DATA_WIDTH(DW)) sif1 ();

  psum_accum_ctrl #(
    .DATA_WIDTH(DW), .OFM_SIZE(OFM), .NUM_CHANNEL(NC), .ADDR_WIDTH(2), .CH_WIDTH(2)
  ) dut (
    .clk1(clk1), .rst_n(rst_n), .start_conv(start_conv), .psum_if(sif.slave),
    .cnt_channel(cnt_channel), .last_channel(last_channel), .busy(busy),
    .done(done), .sat_flag(sat_flag)
  );

  psum_accum_ctrl #(
    .DATA_WIDTH(DW), .OFM_SIZE(OFM), .NUM_CHANNEL(1), .ADDR_WIDTH(2), .CH_WIDTH(1)
  ) dut1 (
    .clk1(clk1), .rst_n(rst_n), .start_conv(start1), .psum_if(sif1.slave),
    .cnt_channel(cnt1), .last_channel(last1), .busy(busy1),
    .done(done1), .sat_flag(sat1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: running per-pixel totals, clamped to the 16-bit signed range.
  int stim [NC][PIX];
  int acc [PIX];
  bit sat_exp;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp1_q[$];
  logic [DW-1:0] mon_e, mon_e1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clamp16(input int s);
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic int rnd16();
    logic signed [15:0] r;
    r = 16'($urandom);
    return int'(r);
  endfunction

  task automatic model_psum(input int c, input int p, input int v);
    int s;
    if (c == 0) begin
      acc[p] = v;
    end else begin
      s = acc[p] + v;
      if (s != clamp16(s)) sat_exp = 1'b1;
      acc[p] = clamp16(s);
    end
    if (c == NC - 1) exp_q.push_back(16'(acc[p]));
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  // Scoreboard monitors: one compare per cycle in which an output beat is presented.
  always @(negedge clk1) begin
    if (rst_n && sif.data_output_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d expected no beat at %0t",
                 $signed(sif.data_output), $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_output", int'($signed(sif.data_output)), int'($signed(mon_e)));
      end
    end
  end

  always @(negedge clk1) begin
    if (rst_n && sif1.data_output_valid) begin
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output_nc1: got %0d expected no beat at %0t",
                 $signed(sif1.data_output), $time);
      end else begin
        mon_e1 = exp1_q.pop_front();
        check("data_output_nc1", int'($signed(sif1.data_output)), int'($signed(mon_e1)));
      end
    end
  end

  task automatic run(input int max_gap, input bit poke_start);
    sat_exp = 1'b0;
    start_conv = 1'b1;
    tick();
    start_conv = 1'b0;
    check("busy_after_start", busy, 1);
    check("sat_cleared_on_start", sat_flag, 0);
    check("cnt_channel_start", cnt_channel, 0);
    for (int c = 0; c < NC; c++) begin
      for (int p = 0; p < PIX; p++) begin
        repeat ($urandom_range(max_gap, 0)) tick();
        check("cnt_channel", cnt_channel, c);
        check("last_channel", last_channel, (c == NC - 1) ? 1 : 0);
        sif.psum_valid = 1'b1;
        sif.psum_in    = 16'(stim[c][p]);
        if (poke_start && c == 1 && p == 1) start_conv = 1'b1;
        model_psum(c, p, stim[c][p]);
        tick();
        sif.psum_valid = 1'b0;
        start_conv     = 1'b0;
        if (c == NC - 1) check("output_valid_latency", sif.data_output_valid, 1);
        if (c == NC - 1 && p == PIX - 1) begin
          check("done_after_last", done, 1);
          check("busy_in_done", busy, 0);
        end else begin
          check("done_early", done, 0);
        end
      end
    end
    check("sat_flag", sat_flag, sat_exp ? 1 : 0);
    tick();
    check("done_pulse_width", done, 0);
    check("busy_idle", busy, 0);
    check("pending_outputs", exp_q.size(), 0);
  endtask

  task automatic load_basic();
    for (int p = 0; p < PIX; p++) begin
      stim[0][p] = p + 1;
      stim[1][p] = 10 * (p + 1);
      stim[2][p] = 100 * (p + 1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int nc1_vals [PIX];
    rst_n = 1'b0;
    start_conv = 1'b0;
    start1 = 1'b0;
    sif.psum_valid = 1'b0;
    sif.psum_in = '0;
    sif1.psum_valid = 1'b0;
    sif1.psum_in = '0;
    #12;
    check("reset_data_output", sif.data_output, 0);
    check("reset_data_output_valid", sif.data_output_valid, 0);
    check("reset_last_channel", last_channel, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_sat_flag", sat_flag, 0);
    check("reset_cnt_channel", cnt_channel, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic accumulate
    load_basic();
    run(0, 1'b0);

    // Saturation at pixels 0 (positive) and 1 (negative)
    for (int c = 0; c < NC; c++) begin
      stim[c][0] = 32'sh7000;
      stim[c][1] = -32'sh7000;
      stim[c][2] = c + 7;
      stim[c][3] = -c;
    end
    run(0, 1'b0);
    check("sat_flag_set", sat_flag, 1);

    // Psum pulses while idle must be ignored
    for (int i = 0; i < 3; i++) begin
      sif.psum_valid = 1'b1;
      sif.psum_in = 16'(rnd16());
      tick();
      sif.psum_valid = 1'b0;
      check("idle_no_output", sif.data_output_valid, 0);
      tick();
    end
    // Gaps plus a stray start_conv mid-run; also clears sat_flag from the previous run
    load_basic();
    run(5, 1'b1);

    // Reset during channel 1, pixel 2
    start_conv = 1'b1;
    tick();
    start_conv = 1'b0;
    for (int i = 0; i < PIX + 2; i++) begin
      sif.psum_valid = 1'b1;
      sif.psum_in = 16'(rnd16());
      tick();
    end
    sif.psum_in = 16'd77;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_data_output", sif.data_output, 0);
    check("midrst_data_output_valid", sif.data_output_valid, 0);
    check("midrst_last_channel", last_channel, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_sat_flag", sat_flag, 0);
    check("midrst_cnt_channel", cnt_channel, 0);
    sif.psum_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < PIX; p++) stim[c][p] = 5;
    run(0, 1'b0);

    // Back-to-back random runs: each start_conv on the cycle after done
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < NC; c++)
        for (int p = 0; p < PIX; p++) stim[c][p] = (r < 2) ? (rnd16() >>> 4) : rnd16();
      run((r % 2 == 0) ? 0 : 2, 1'b0);
    end

    // Single-channel instance
    nc1_vals[0] = -3;
    nc1_vals[1] = 0;
    nc1_vals[2] = 7;
    nc1_vals[3] = 9;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    for (int p = 0; p < PIX; p++) begin
      check("nc1_last_channel", last1, 1);
      sif1.psum_valid = 1'b1;
      sif1.psum_in = 16'(nc1_vals[p]);
      exp1_q.push_back(16'(nc1_vals[p]));
      tick();
      sif1.psum_valid = 1'b0;
    end
    check("nc1_done", done1, 1);
    check("nc1_sat_flag", sat1, 0);
    tick();
    check("nc1_done_clear", done1, 0);
    check("nc1_pending_outputs", exp1_q.size(), 0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
